// File: rtl/fir_axis_decim.sv
// ---------------------------------------------------------------------------
// fir_axis_decim
//   AXI4-Stream decimator that sits directly after the FIR output stream.
//   It keeps one of every FACTOR accepted samples, at phase OFFSET within each
//   group, and discards the rest. The last beat of a packet is always kept, so
//   packet boundaries survive decimation. Kept beats pass through a 2-entry
//   buffer (output register plus skid register), so S_AXIS_TREADY depends only
//   on registered state and never on M_AXIS_TREADY.
//
// Ports
//   S_AXIS_ACLK     in   clock
//   S_AXIS_ARESETN  in   synchronous reset, active-low
//   S_AXIS_TVALID   in   input beat valid
//   S_AXIS_TREADY   out  input beat can be accepted (buffer not full)
//   S_AXIS_TDATA    in   input sample
//   S_AXIS_TLAST    in   input beat ends packet
//   M_AXIS_TVALID   out  output beat valid
//   M_AXIS_TREADY   in   downstream accepts output beat
//   M_AXIS_TDATA    out  kept sample
//   M_AXIS_TLAST    out  output beat ends packet
//   DROP_CNT        out  number of discarded beats, saturating at all-ones
// ---------------------------------------------------------------------------
module fir_axis_decim #(
  parameter int FACTOR     = 2,
  parameter int OFFSET     = 0,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic [CNT_WIDTH-1:0]  DROP_CNT
);

  // Reject meaningless configurations at elaboration time.
  generate
    if (FACTOR < 1 || OFFSET < 0 || OFFSET >= FACTOR) begin : g_bad_param
      $error("fir_axis_decim: need FACTOR>=1 and 0<=OFFSET<FACTOR");
    end
  endgenerate

  // Phase counter is at least one bit wide so FACTOR=1 still elaborates;
  // in that case it simply stays at 0.
  localparam int            PW     = (FACTOR > 1) ? $clog2(FACTOR) : 1;
  localparam logic [PW-1:0] OFF_P  = PW'(OFFSET);
  localparam logic [PW-1:0] LAST_P = PW'(FACTOR - 1);

  // Head entry drives M_AXIS_* directly; skid entry holds the second beat.
  logic                  head_vld_q,  head_vld_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic                  head_last_q, head_last_d;
  logic                  skid_vld_q,  skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic [PW-1:0]         phase_q,     phase_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q,  drop_cnt_d;

  logic in_acc;
  logic keep;
  logic push;
  logic drop;
  logic pop;

  // Full only when both entries hold a beat; registered state only.
  assign S_AXIS_TREADY = ~(head_vld_q & skid_vld_q);
  assign M_AXIS_TVALID = head_vld_q;
  assign M_AXIS_TDATA  = head_data_q;
  assign M_AXIS_TLAST  = head_last_q;
  assign DROP_CNT      = drop_cnt_q;

  always_comb begin
    in_acc = S_AXIS_TVALID & S_AXIS_TREADY;
    // A last beat is always kept so every packet emits exactly one TLAST.
    keep   = (phase_q == OFF_P) | S_AXIS_TLAST;
    push   = in_acc & keep;
    drop   = in_acc & ~keep;
    pop    = head_vld_q & M_AXIS_TREADY;

    // Phase: wraps at FACTOR-1, and TLAST restarts the next packet at 0.
    phase_d = phase_q;
    if (in_acc) begin
      if (S_AXIS_TLAST || phase_q == LAST_P) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != {CNT_WIDTH{1'b1}}) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    head_vld_d  = head_vld_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;

    if (pop) begin
      if (skid_vld_q) begin
        // Older skid beat moves forward; a new push refills the skid.
        head_vld_d  = 1'b1;
        head_data_d = skid_data_q;
        head_last_d = skid_last_q;
        if (push) begin
          skid_data_d = S_AXIS_TDATA;
          skid_last_d = S_AXIS_TLAST;
        end else begin
          skid_vld_d = 1'b0;
        end
      end else begin
        // Head drained; a same-cycle push refills it directly.
        head_vld_d = push;
        if (push) begin
          head_data_d = S_AXIS_TDATA;
          head_last_d = S_AXIS_TLAST;
        end
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_vld_d  = 1'b1;
        head_data_d = S_AXIS_TDATA;
        head_last_d = S_AXIS_TLAST;
      end else begin
        // TREADY guarantees the skid entry is free here.
        skid_vld_d  = 1'b1;
        skid_data_d = S_AXIS_TDATA;
        skid_last_d = S_AXIS_TLAST;
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (!S_AXIS_ARESETN) begin
      head_vld_q  <= 1'b0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      phase_q     <= '0;
      drop_cnt_q  <= '0;
    end else begin
      head_vld_q  <= head_vld_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      phase_q     <= phase_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_fir_axis_decim.sv
// ---------------------------------------------------------------------------
// tb_fir_axis_decim
//   Four decimator instances with different configurations share one clock:
//     unit 0: FACTOR=2 OFFSET=0 CNT_WIDTH=16
//     unit 1: FACTOR=4 OFFSET=1 CNT_WIDTH=16
//     unit 2: FACTOR=1 OFFSET=0 CNT_WIDTH=16
//     unit 3: FACTOR=2 OFFSET=0 CNT_WIDTH=4
//   Expected outputs come from a packet-position model: beat number k within
//   its packet is kept when k mod FACTOR == OFFSET or when it carries TLAST.
// ---------------------------------------------------------------------------
module tb_fir_axis_decim;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn;
  logic [3:0]       s_valid, s_tready, s_last, m_valid, m_ready, m_last;
  logic [3:0][15:0] s_data, m_data, drop_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      localparam int F  = (gi == 0) ? 2 : (gi == 1) ? 4 : (gi == 2) ? 1 : 2;
      localparam int O  = (gi == 1) ? 1 : 0;
      localparam int CW = (gi == 3) ? 4 : 16;
      logic [CW-1:0] dc;
      fir_axis_decim #(.FACTOR(F), .OFFSET(O), .DATA_WIDTH(16), .CNT_WIDTH(CW)) u_dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rstn),
        .S_AXIS_TVALID  (s_valid[gi]),
        .S_AXIS_TREADY  (s_tready[gi]),
        .S_AXIS_TDATA   (s_data[gi]),
        .S_AXIS_TLAST   (s_last[gi]),
        .M_AXIS_TVALID  (m_valid[gi]),
        .M_AXIS_TREADY  (m_ready[gi]),
        .M_AXIS_TDATA   (m_data[gi]),
        .M_AXIS_TLAST   (m_last[gi]),
        .DROP_CNT       (dc)
      );
      assign drop_cnt[gi] = 16'(dc);
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  int in_d[$];
  bit in_l[$];
  int exp_d[$];
  bit exp_l[$];
  int got_d[$];
  bit got_l[$];
  int exp_drop;
  int stab_viol;
  bit saw_full;
  bit timed_out;

  function automatic int uf(input int u);
    return (u == 0) ? 2 : (u == 1) ? 4 : (u == 2) ? 1 : 2;
  endfunction
  function automatic int uo(input int u);
    return (u == 1) ? 1 : 0;
  endfunction
  function automatic int ucw(input int u);
    return (u == 3) ? 4 : 16;
  endfunction

  // Reference: position within packet, modulo rule, saturating drop count.
  task automatic model(input int u);
    int pos;
    int maxc;
    pos = 0;
    maxc = (1 << ucw(u)) - 1;
    exp_d.delete();
    exp_l.delete();
    exp_drop = 0;
    for (int i = 0; i < in_d.size(); i++) begin
      if ((pos % uf(u)) == uo(u) || in_l[i]) begin
        exp_d.push_back(in_d[i]);
        exp_l.push_back(in_l[i]);
      end else if (exp_drop < maxc) begin
        exp_drop++;
      end
      pos = in_l[i] ? 0 : pos + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn    = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Drives in_d/in_l into unit u and collects output beats until the model's
  // count is reached. rmode: 0 ready=1, 1 random, 2 ready=0 for cycles [slo,shi).
  task automatic run(input int u, input int rmode, input int slo, input int shi,
                     input int vprob, input int budget);
    int   cyc;
    bit   pend;
    bit   mr;
    bit   prev_stall;
    logic [15:0] prev_d;
    logic prev_l;
    cyc = 0; pend = 0; prev_stall = 0; prev_d = '0; prev_l = 0;
    got_d.delete(); got_l.delete();
    stab_viol = 0; saw_full = 0; timed_out = 0;
    while ((in_d.size() > 0 || got_d.size() < exp_d.size()) && cyc < budget) begin
      @(negedge clk);
      if (prev_stall && (m_valid[u] !== 1'b1 || m_data[u] !== prev_d || m_last[u] !== prev_l))
        stab_viol++;
      case (rmode)
        0:       mr = 1'b1;
        1:       mr = 1'($urandom_range(1));
        default: mr = !(cyc >= slo && cyc < shi);
      endcase
      m_ready[u] = mr;
      if (!pend && in_d.size() > 0 && $urandom_range(99) < vprob) pend = 1;
      s_valid[u] = pend;
      s_data[u]  = pend ? 16'(in_d[0]) : 16'h0;
      s_last[u]  = pend ? in_l[0] : 1'b0;
      if (s_tready[u] === 1'b0) saw_full = 1;
      if (pend && s_tready[u] === 1'b1) begin
        void'(in_d.pop_front());
        void'(in_l.pop_front());
        pend = 0;
      end
      if (m_valid[u] === 1'b1 && mr) begin
        got_d.push_back(int'(m_data[u]));
        got_l.push_back(m_last[u]);
      end
      prev_stall = (m_valid[u] === 1'b1) && !mr;
      prev_d = m_data[u];
      prev_l = m_last[u];
      cyc++;
    end
    if (cyc >= budget) timed_out = 1;
    @(negedge clk);
    s_valid[u] = 1'b0;
    s_last[u]  = 1'b0;
    m_ready[u] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (m_valid[u] !== 1'b0 || m_data[u] !== 16'h0 || m_last[u] !== 1'b0 ||
          drop_cnt[u] !== 16'h0 || s_tready[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset unit%0d: valid=%b data=%h last=%b drop=%0d tready=%b, required 0,0,0,0,1",
                 u, m_valid[u], m_data[u], m_last[u], drop_cnt[u], s_tready[u]);
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_decim_f2();
    do_reset();
    in_d.delete(); in_l.delete();
    for (int i = 0; i < 8; i++) begin in_d.push_back(i); in_l.push_back(i == 7); end
    model(0);
    run(0, 0, 0, 0, 100, 200);
    checks++;
    if (timed_out || got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL f2 count: got %0d beats, required %0d (timeout=%0d)", got_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL f2 beat%0d: got %0d/%0d, required %0d/%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (drop_cnt[0] !== 16'(exp_drop) || m_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL f2 drop/idle: drop=%0d valid=%b, required drop=%0d valid=0", drop_cnt[0], m_valid[0], exp_drop);
    end
    $display("test_decim_f2: %0d beats out, drop=%0d", got_d.size(), drop_cnt[0]);
  endtask

  task automatic test_decim_f4_packets();
    do_reset();
    in_d.delete(); in_l.delete();
    for (int i = 0; i < 12; i++) begin in_d.push_back(i); in_l.push_back(i == 11); end
    for (int i = 20; i < 24; i++) begin in_d.push_back(i); in_l.push_back(i == 23); end
    model(1);
    run(1, 0, 0, 0, 100, 200);
    checks++;
    if (timed_out || got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL f4 count: got %0d beats, required %0d (timeout=%0d)", got_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL f4 beat%0d: got %0d/%0d, required %0d/%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (drop_cnt[1] !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL f4 drop: got %0d, required %0d", drop_cnt[1], exp_drop);
    end
    $display("test_decim_f4_packets: %0d beats out, drop=%0d", got_d.size(), drop_cnt[1]);
  endtask

  task automatic test_backpressure();
    do_reset();
    in_d.delete(); in_l.delete();
    for (int i = 0; i < 30; i++) begin in_d.push_back(i + 1000); in_l.push_back(i == 29); end
    model(0);
    run(0, 2, 3, 13, 100, 300);
    checks++;
    if (timed_out || got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL bp count: got %0d beats, required %0d (timeout=%0d)", got_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL bp beat%0d: got %0d/%0d, required %0d/%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (saw_full !== 1'b1 || stab_viol != 0) begin
      errors++;
      $display("FAIL bp full/hold: saw_tready_low=%0d hold_violations=%0d, required 1 and 0", saw_full, stab_viol);
    end
    checks++;
    if (drop_cnt[0] !== 16'(exp_drop) || m_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp drop/idle: drop=%0d valid=%b, required drop=%0d valid=0", drop_cnt[0], m_valid[0], exp_drop);
    end
    $display("test_backpressure: %0d beats out, drop=%0d", got_d.size(), drop_cnt[0]);
  endtask

  task automatic test_passthrough();
    do_reset();
    in_d.delete(); in_l.delete();
    for (int i = 100; i < 104; i++) begin in_d.push_back(i); in_l.push_back(i == 103); end
    model(2);
    run(2, 1, 0, 0, 100, 200);
    checks++;
    if (timed_out || got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL pass count: got %0d beats, required %0d (timeout=%0d)", got_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL pass beat%0d: got %0d/%0d, required %0d/%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (drop_cnt[2] !== 16'h0 || stab_viol != 0) begin
      errors++;
      $display("FAIL pass drop/hold: drop=%0d hold_violations=%0d, required 0 and 0", drop_cnt[2], stab_viol);
    end
    $display("test_passthrough: %0d beats out, drop=%0d", got_d.size(), drop_cnt[2]);
  endtask

  task automatic test_midreset();
    do_reset();
    // Beats 0,1,2 with output stalled: 0 and 2 kept, buffer fills.
    for (int i = 0; i < 3; i++) begin
      s_valid[0] = 1'b1; s_data[0] = 16'(i); s_last[0] = 1'b0; m_ready[0] = 1'b0;
      @(negedge clk);
    end
    s_valid[0] = 1'b0;
    checks++;
    if (s_tready[0] !== 1'b0 || m_valid[0] !== 1'b1 || m_data[0] !== 16'd0 || drop_cnt[0] !== 16'd1) begin
      errors++;
      $display("FAIL midreset full: tready=%b valid=%b data=%0d drop=%0d, required 0,1,0,1",
               s_tready[0], m_valid[0], m_data[0], drop_cnt[0]);
    end
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if (m_valid[0] !== 1'b0 || drop_cnt[0] !== 16'd0 || s_tready[0] !== 1'b1) begin
      errors++;
      $display("FAIL midreset clear: valid=%b drop=%0d tready=%b, required 0,0,1",
               m_valid[0], drop_cnt[0], s_tready[0]);
    end
    in_d.delete(); in_l.delete();
    for (int i = 0; i < 4; i++) begin in_d.push_back(i); in_l.push_back(i == 3); end
    model(0);
    run(0, 0, 0, 0, 100, 200);
    checks++;
    if (timed_out || got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL midreset count: got %0d beats, required %0d (timeout=%0d)", got_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL midreset beat%0d: got %0d/%0d, required %0d/%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    $display("test_midreset: %0d beats out after reset", got_d.size());
  endtask

  task automatic test_saturation();
    do_reset();
    in_d.delete(); in_l.delete();
    for (int i = 0; i < 40; i++) begin in_d.push_back(i * 3); in_l.push_back(1'b0); end
    model(3);
    run(3, 0, 0, 0, 100, 300);
    checks++;
    if (timed_out || got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL sat count: got %0d beats, required %0d (timeout=%0d)", got_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL sat beat%0d: got %0d/%0d, required %0d/%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (drop_cnt[3] !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL sat drop: got %0d, required %0d", drop_cnt[3], exp_drop);
    end
    $display("test_saturation: %0d beats out, drop=%0d", got_d.size(), drop_cnt[3]);
  endtask

  task automatic test_random();
    do_reset();
    in_d.delete(); in_l.delete();
    for (int i = 0; i < 60; i++) begin
      in_d.push_back(int'($urandom_range(65535)));
      in_l.push_back($urandom_range(6) == 0 || i == 59);
    end
    model(1);
    run(1, 1, 0, 0, 70, 2000);
    checks++;
    if (timed_out || got_d.size() != exp_d.size()) begin
      errors++;
      $display("FAIL rand count: got %0d beats, required %0d (timeout=%0d)", got_d.size(), exp_d.size(), timed_out);
    end
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      checks++;
      if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i]) begin
        errors++;
        $display("FAIL rand beat%0d: got %0d/%0d, required %0d/%0d", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (drop_cnt[1] !== 16'(exp_drop) || stab_viol != 0 || m_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL rand drop/hold: drop=%0d hold_violations=%0d valid=%b, required drop=%0d 0 0",
               drop_cnt[1], stab_viol, m_valid[1], exp_drop);
    end
    $display("test_random: %0d beats out, drop=%0d", got_d.size(), drop_cnt[1]);
  endtask

  initial begin
    rstn    = 1'b0;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = '0;
    test_reset();
    test_decim_f2();
    test_decim_f4_packets();
    test_backpressure();
    test_passthrough();
    test_midreset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
